// File: rtl/egress_tag_buffer_pkg.sv
// Shared defaults and helper types for the egress tag buffer.
// The size defaults come from the arbitrated FIFO top's define header when it is compiled first.
`ifndef NUM_FIFOS
`define NUM_FIFOS 4
`endif
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef DEPTH
`define DEPTH 4
`endif

package egress_tag_buffer_pkg;

   localparam int DEF_NUM_FIFOS = `NUM_FIFOS;
   localparam int DEF_WIDTH     = `WIDTH;
   localparam int DEF_DEPTH     = `DEPTH;

   // Encoded as {pop, push} so the occupancy update can be written as a single case.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   function automatic op_e op_of(input logic push, input logic pop);
      return op_e'({pop, push});
   endfunction

endpackage

// File: rtl/egress_tag_buffer_if.sv
// Upstream grant/beat and downstream head-beat signals of the egress tag buffer.
interface egress_tag_buffer_if
   import egress_tag_buffer_pkg::*;
#(
   parameter int NUM_FIFOS = DEF_NUM_FIFOS,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_FIFOS-1:0] gnt;
   logic [WIDTH-1:0]     data_in;
   logic                 out_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [TAGWIDTH-1:0]  out_tag;
   logic                 arb_stall;
   logic [CW-1:0]        count;
   logic                 overflow_err;
   logic                 onehot_err;

   modport master (
      output gnt, data_in, out_ready,
      input  out_valid, out_data, out_tag, arb_stall, count, overflow_err, onehot_err
   );

   modport slave (
      input  gnt, data_in, out_ready,
      output out_valid, out_data, out_tag, arb_stall, count, overflow_err, onehot_err
   );

endinterface

// File: rtl/egress_tag_buffer_onehot_encoder.sv
// Converts a grant vector to the binary index of its set bit and flags whether it is one-hot.
module onehot_encoder #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         is_onehot
);

   // OR-ing all set-bit indices is exact for one-hot inputs; other inputs are never stored.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = idx | W'(i);
      end
   end

   assign is_onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/egress_tag_buffer.sv
// Small tagged FIFO between the upstream arbiter and the egress port.
// Stores {tag, data} per beat, exposes the head combinationally and keeps sticky error flags.
module egress_tag_buffer
   import egress_tag_buffer_pkg::*;
#(
   parameter int NUM_FIFOS = DEF_NUM_FIFOS,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) (
   input logic              clk,
   input logic              rst,
   egress_tag_buffer_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = TAGWIDTH + WIDTH;

   logic [EW-1:0]       mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count_q;
   logic                overflow_q;
   logic                onehot_q;

   logic [TAGWIDTH-1:0] tag;
   logic                is_onehot;
   logic                offered;
   logic                full;
   logic                pop;
   logic                push;
   op_e                 op;

   onehot_encoder #(
      .N (NUM_FIFOS),
      .W (TAGWIDTH)
   ) u_onehot_encoder (
      .vec       (bus.gnt),
      .idx       (tag),
      .is_onehot (is_onehot)
   );

   assign offered = |bus.gnt;
   assign full    = (count_q == CW'(DEPTH));
   assign pop     = (count_q != '0) && bus.out_ready;
   // A pop in the same cycle frees the head slot, so a full buffer can still accept.
   assign push    = offered && is_onehot && (!full || pop);
   assign op      = op_of(push, pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case (op)
            OP_PUSH: count_q <= count_q + CW'(1);
            OP_POP:  count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= {tag, bus.data_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q <= 1'b0;
         onehot_q   <= 1'b0;
      end else begin
         if (offered && !is_onehot)                 onehot_q   <= 1'b1;
         if (offered && is_onehot && full && !pop)  overflow_q <= 1'b1;
      end
   end

   assign bus.out_valid                 = (count_q != '0);
   assign {bus.out_tag, bus.out_data}   = mem[rd_ptr];
   // One entry of slack covers the cycle the arbiter needs to react.
   assign bus.arb_stall                 = (count_q >= CW'(DEPTH - 1));
   assign bus.count                     = count_q;
   assign bus.overflow_err              = overflow_q;
   assign bus.onehot_err                = onehot_q;

`ifdef FORMAL
   logic past_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) past_valid <= 1'b0;
      else     past_valid <= 1'b1;
   end

   always_comb begin
      if (past_valid && !rst) begin
         assert (count_q <= CW'(DEPTH));
         assert (bus.out_valid == (count_q != '0));
      end
   end
`endif

endmodule

// File: tb/tb_egress_tag_buffer.sv
// Directed and random bench for egress_tag_buffer against a queue-based reference model.
module tb_egress_tag_buffer;

   localparam int NF = 4;
   localparam int W  = 8;
   localparam int D  = 4;

   typedef struct {
      int tag;
      int data;
   } beat_t;

   logic clk;
   logic rst;

   egress_tag_buffer_if #(.NUM_FIFOS(NF), .WIDTH(W), .DEPTH(D)) bus ();

   egress_tag_buffer #(
      .NUM_FIFOS (NF),
      .WIDTH     (W),
      .DEPTH     (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   beat_t q[$];
   bit    m_ovf;
   bit    m_ohe;
   int    errors;
   int    checks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int tag_of(input logic [NF-1:0] g);
      for (int i = 0; i < NF; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic check_state();
      chk("count",        32'(bus.count), 32'(q.size()));
      chk("out_valid",    32'(bus.out_valid), 32'(q.size() != 0));
      chk("arb_stall",    32'(bus.arb_stall), 32'(q.size() >= D - 1));
      chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
      chk("onehot_err",   32'(bus.onehot_err), 32'(m_ohe));
      if (q.size() != 0) begin
         chk("out_data", 32'(bus.out_data), 32'(q[0].data));
         chk("out_tag",  32'(bus.out_tag),  32'(q[0].tag));
      end
   endtask

   task automatic model_update(input logic [NF-1:0] g, input logic [W-1:0] d, input logic r);
      int pre;
      bit pop;
      pre = q.size();
      pop = (pre != 0) && r;
      if (pop) void'(q.pop_front());
      if (g != 0) begin
         if ($countones(g) != 1) m_ohe = 1'b1;
         else if (pre < D || pop) q.push_back('{tag_of(g), int'(d)});
         else m_ovf = 1'b1;
      end
   endtask

   task automatic step(input logic [NF-1:0] g, input logic [W-1:0] d, input logic r);
      bus.gnt       = g;
      bus.data_in   = d;
      bus.out_ready = r;
      #1;
      check_state();
      model_update(g, d, r);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.gnt       = '0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      #1;
      chk("rst_count",     32'(bus.count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_arb_stall", 32'(bus.arb_stall), 0);
      chk("rst_out_data",  32'(bus.out_data), 0);
      chk("rst_out_tag",   32'(bus.out_tag), 0);
      chk("rst_ovf",       32'(bus.overflow_err), 0);
      chk("rst_ohe",       32'(bus.onehot_err), 0);
      q.delete();
      m_ovf = 1'b0;
      m_ohe = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      int cyc;
      logic [NF-1:0] g;
      logic [W-1:0]  d;
      int sel;

      errors = 0;
      checks = 0;
      rst    = 1'b1;
      bus.gnt = '0;
      bus.data_in = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // single push, latency 1
      step(4'b0100, 8'hA5, 1'b0);
      chk("r38_valid", 32'(bus.out_valid), 1);
      chk("r38_data",  32'(bus.out_data), 32'h A5);
      chk("r38_tag",   32'(bus.out_tag), 2);
      chk("r38_count", 32'(bus.count), 1);
      step(4'b0000, 8'h00, 1'b1);

      // fill, stall threshold, overflow
      for (int i = 0; i < 4; i++) begin
         step(NF'(1 << i), W'(8'h10 + i), 1'b0);
         if (i == 2) chk("r39_stall_at3", 32'(bus.arb_stall), 1);
      end
      chk("r39_count4", 32'(bus.count), 4);
      step(4'b0001, 8'h77, 1'b0);
      chk("r39_ovf",    32'(bus.overflow_err), 1);
      chk("r39_count",  32'(bus.count), 4);

      // push and pop together while full
      step(4'b1000, 8'hFF, 1'b1);
      chk("r40_count", 32'(bus.count), 4);
      chk("r40_head",  32'(bus.out_data), 32'h11);
      while (q.size() > 1) step(4'b0000, 8'h00, 1'b1);
      chk("r40_last_data", 32'(bus.out_data), 32'hFF);
      chk("r40_last_tag",  32'(bus.out_tag), 3);
      step(4'b0000, 8'h00, 1'b1);

      // multi-hot grant on empty buffer
      step(4'b0110, 8'h55, 1'b0);
      chk("r41_ohe",   32'(bus.onehot_err), 1);
      chk("r41_count", 32'(bus.count), 0);
      chk("r41_valid", 32'(bus.out_valid), 0);

      // streaming with wrap, stall honoured
      do_reset();
      pushed = 0;
      cyc = 0;
      while ((pushed < 10 || q.size() != 0) && cyc < 100) begin
         g = '0;
         d = '0;
         if (pushed < 10 && q.size() < D - 1) begin
            g = NF'(1 << (pushed % NF));
            d = W'(8'h30 + pushed);
            pushed++;
         end
         step(g, d, (cyc % 2) == 0);
         cyc++;
      end
      chk("r42_drained", 32'(q.size() == 0 && pushed == 10), 1);
      chk("r42_ovf", 32'(bus.overflow_err), 0);
      chk("r42_ohe", 32'(bus.onehot_err), 0);

      // reset mid-operation
      for (int i = 0; i < 3; i++) step(NF'(1 << i), W'(8'h60 + i), 1'b0);
      chk("r43_pre_count", 32'(bus.count), 3);
      do_reset();
      step(4'b0010, 8'h9C, 1'b0);
      chk("r43_data",  32'(bus.out_data), 32'h9C);
      chk("r43_tag",   32'(bus.out_tag), 1);
      chk("r43_count", 32'(bus.count), 1);

      // random traffic
      do_reset();
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 15));
         if (sel < 3)       g = '0;
         else if (sel < 15) g = NF'(1 << $urandom_range(0, NF - 1));
         else               g = NF'($urandom_range(0, (1 << NF) - 1));
         d = W'($urandom);
         step(g, d, 1'($urandom_range(0, 1)));
      end
      step(4'b0000, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/egress_tag_buffer.md
EGRESS_TAG_BUFFER -- requirements
Module: egress_tag_buffer

Interface
REQ-001 Parameter NUM_FIFOS, default `NUM_FIFOS (4), number of upstream arbitrated sources.
REQ-002 Parameter WIDTH, default `WIDTH (8), data beat width in bits.
REQ-003 Parameter DEPTH, default `DEPTH (4), buffer entries; power of two, >= 2.
REQ-004 Parameter TAGWIDTH, default $clog2(NUM_FIFOS), source tag width.
REQ-005 One clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 gnt  input  NUM_FIFOS  upstream grant vector; nonzero marks a popped beat this cycle.
REQ-009 data_in  input  WIDTH  upstream muxed beat, valid when gnt != 0.
REQ-010 out_ready  input  1  downstream accepts the head beat.
REQ-011 out_valid  output  1  head beat present.
REQ-012 out_data  output  WIDTH  head beat data.
REQ-013 out_tag  output  TAGWIDTH  head beat source index.
REQ-014 arb_stall  output  1  upstream withholds requests.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 overflow_err  output  1  sticky: beat dropped because buffer full.
REQ-017 onehot_err  output  1  sticky: gnt had more than one bit set.

Function
REQ-018 Beat offered when gnt != 0; tag = binary index of the set gnt bit.
REQ-019 Offered beat with non-one-hot gnt is dropped and onehot_err sets on the next edge.
REQ-020 Pop occurs when out_valid && out_ready.
REQ-021 Push occurs when beat offered, gnt one-hot, and (count < DEPTH or pop same cycle).
REQ-022 Offered one-hot beat with count == DEPTH and no pop is dropped; overflow_err sets next edge.
REQ-023 Simultaneous push and pop leave count unchanged; the pushed entry goes to the tail, the popped entry leaves the head.
REQ-024 Pushed beat is visible at out_data/out_tag one cycle after the push edge when the buffer was empty (latency 1).
REQ-025 out_valid = (count != 0); out_data/out_tag reflect head storage directly, no extra read latency.
REQ-026 out_data/out_tag hold stable while out_valid && !out_ready.
REQ-027 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count never exceeds DEPTH.
REQ-028 arb_stall = (count >= DEPTH-1), combinational from count, giving one entry of slack for the one-cycle upstream reaction.
REQ-029 Error flags remain set until reset; they do not block further operation.
REQ-030 With gnt == 0, no push, no error update.

Reset
REQ-031 While rst is high: pointers and count 0, out_valid 0, arb_stall 0 (DEPTH >= 2), overflow_err 0, onehot_err 0.
REQ-032 out_data and out_tag read 0 after reset; storage contents are otherwise unspecified.
REQ-033 Reset asserted mid-operation discards all buffered beats asynchronously; first push after deassertion lands at entry 0.

Structure
REQ-034 NUM_FIFOS, WIDTH, DEPTH defaults come from the shared define header used by the arbitrated FIFO top; no new constants are defined locally.
REQ-035 One sub-module, onehot_encoder (NUM_FIFOS -> TAGWIDTH index plus is_onehot flag), is instantiated for tag generation.
REQ-036 Storage holds {tag, data} per entry as a register array; no vendor RAM.
REQ-037 Under FORMAL, the block asserts count <= DEPTH and out_valid == (count != 0) on every non-initial cycle.

Verification
REQ-038 Reset, then gnt=4'b0100 data_in=8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, out_tag=2, count=1.
REQ-039 Four pushes (tags 0,1,2,3, data 8'h10..8'h13) with out_ready=0 -> count=4, arb_stall=1 from count=3; fifth push gnt=4'b0001 -> overflow_err=1, count stays 4.
REQ-040 Full buffer, out_ready=1 and gnt=4'b1000 data 8'hFF same cycle -> count stays 4, head advances to 8'h11, 8'hFF later pops last with tag 3.
REQ-041 gnt=4'b0110 data 8'h55 on an empty buffer -> onehot_err=1, count=0, out_valid=0.
REQ-042 Stream 10 beats with out_ready toggling 1,0,1,0 -> pointers wrap, all beats out in order with correct tags, no errors.
REQ-043 Reset asserted with count=3 -> out_valid=0, count=0 immediately; next push appears at head with latency 1.
